reset_request_gen: RTL and testbench

RESET_REQUEST_GEN -- requirements
Module: reset_request_gen

---
 rtl/reset_request_gen.sv | 149 ++++++++++++++
 tb/tb_reset_request_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/reset_request_gen.sv
// reset_request_gen
// Produces a fixed-width, registered reset request pulse from either a
// debounced pushbutton or a synchronous software request. It also gives a
// power-on stretch after reset and a hold-off window that blocks re-triggering.
// The cause output records which source started the most recent pulse.

module reset_request_gen #(
  parameter int DEBOUNCE_CNT   = 500000,
  parameter int PULSE_CYCLES   = 16,
  parameter int HOLDOFF_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       sw_req,
  output logic       rst_req,
  output logic       busy,
  output logic [1:0] cause
);

  // One shared counter. It must be wide enough for the largest of the three terminal values.
  localparam int MAX_A    = (DEBOUNCE_CNT > PULSE_CYCLES) ? DEBOUNCE_CNT : PULSE_CYCLES;
  localparam int MAX_CNT  = (MAX_A > HOLDOFF_CYCLES) ? MAX_A : HOLDOFF_CYCLES;
  localparam int CW       = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] C_ONE        = CW'(1);
  localparam logic [CW-1:0] C_ZERO       = CW'(0);
  localparam logic [CW-1:0] C_DEB_LAST   = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] C_PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] C_HOLD       = CW'(HOLDOFF_CYCLES);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_ASSERT   = 2'd2;
  localparam logic [1:0] ST_HOLDOFF  = 2'd3;

  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;
  localparam logic [1:0] CAUSE_POR = 2'b11;

  logic          r_sync1;
  logic          r_sync2;
  logic          w_btn_s;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_cause;
  logic          r_rst_req;
  logic          r_busy;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_cause_nxt;

  assign w_btn_s = r_sync2;

  // Two-flop synchronizer that brings the asynchronous button into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state logic. A software request wins over the button. Hold-off waits for button release.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cause_nxt = r_cause;
    case (r_state)
      ST_IDLE: begin
        if (sw_req) begin
          w_state_nxt = ST_ASSERT;
          w_cnt_nxt   = C_ZERO;
          w_cause_nxt = CAUSE_SW;
        end else if (w_btn_s) begin
          w_state_nxt = ST_DEBOUNCE;
          w_cnt_nxt   = C_ONE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DEBOUNCE: begin
        if (sw_req) begin
          w_state_nxt = ST_ASSERT;
          w_cnt_nxt   = C_ZERO;
          w_cause_nxt = CAUSE_SW;
        end else if (!w_btn_s) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = C_ZERO;
        end else if (r_cnt == C_DEB_LAST) begin
          // This edge takes the DEBOUNCE_CNT-th consecutive high sample.
          w_state_nxt = ST_ASSERT;
          w_cnt_nxt   = C_ZERO;
          w_cause_nxt = CAUSE_BTN;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      ST_ASSERT: begin
        if (r_cnt == C_PULSE_LAST) begin
          w_state_nxt = ST_HOLDOFF;
          w_cnt_nxt   = C_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      ST_HOLDOFF: begin
        if ((r_cnt == C_HOLD) && !w_btn_s) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = C_ZERO;
        end else if (r_cnt < C_HOLD) begin
          w_cnt_nxt = r_cnt + C_ONE;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      default: begin
        // An unreachable encoding recovers by issuing a fresh pulse.
        w_state_nxt = ST_ASSERT;
        w_cnt_nxt   = C_ZERO;
        w_cause_nxt = CAUSE_POR;
      end
    endcase
  end

  // State, counter, cause and the output flops. The outputs are registered from the next state, so they are glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_ASSERT;
      r_cnt     <= C_ZERO;
      r_cause   <= CAUSE_POR;
      r_rst_req <= 1'b1;
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cause   <= w_cause_nxt;
      r_rst_req <= (w_state_nxt == ST_ASSERT);
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  assign rst_req = r_rst_req;
  assign busy    = r_busy;
  assign cause   = r_cause;

endmodule

// File: tb/tb_reset_request_gen.sv
// Testbench for reset_request_gen. The stimulus process advances a
// pulse/hold-off/press-run reference model and queues the expected outputs
// for each clock edge. A monitor process pops one expectation per edge and
// compares it with the DUT outputs.

module tb_reset_request_gen;

  localparam int D = 8;
  localparam int P = 4;
  localparam int H = 6;

  logic       clk;
  logic       reset;
  logic       btn_raw;
  logic       sw_req;
  logic       rst_req;
  logic       busy;
  logic [1:0] cause;

  int vectors;
  int errors;

  logic [3:0] exp_q[$];

  // Reference model state. It counts down the pulse, ages the hold-off and tracks the length of the press.
  logic m_s1, m_s2;
  int   m_pulse_left;
  int   m_hold_age;
  int   m_run;
  logic [1:0] m_cause;

  reset_request_gen #(
    .DEBOUNCE_CNT  (D),
    .PULSE_CYCLES  (P),
    .HOLDOFF_CYCLES(H)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_raw),
    .sw_req (sw_req),
    .rst_req(rst_req),
    .busy   (busy),
    .cause  (cause)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  function automatic logic [3:0] model_out();
    logic r, b;
    r = (m_pulse_left > 0);
    b = (m_pulse_left > 0) || (m_hold_age >= 0) || (m_run > 0);
    return {r, b, m_cause};
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got rst_req/busy/cause=%b expected %b", name, $time, got, exp);
    end
  endtask

  // Advance the reference model by one clock edge with the given inputs.
  task automatic model_tick(input logic r, input logic b, input logic s);
    logic bs;
    if (r) begin
      m_s1 = 1'b0; m_s2 = 1'b0;
      m_pulse_left = P; m_hold_age = -1; m_run = 0; m_cause = 2'b11;
    end else begin
      bs = m_s2;
      m_s2 = m_s1;
      m_s1 = b;
      if (m_pulse_left > 0) begin
        m_pulse_left--;
        if (m_pulse_left == 0) m_hold_age = 0;
      end else if (m_hold_age >= 0) begin
        if (m_hold_age >= H && !bs) m_hold_age = -1;
        else if (m_hold_age < H) m_hold_age++;
      end else if (s) begin
        m_pulse_left = P; m_cause = 2'b10; m_run = 0;
      end else if (bs) begin
        m_run++;
        if (m_run == D) begin
          m_pulse_left = P; m_cause = 2'b01; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  // Drive one cycle of inputs just after a falling edge and queue the expected outputs for the next rising edge.
  task automatic step(input logic r, input logic b, input logic s);
    logic prev_r;
    prev_r  = reset;
    reset   = r;
    btn_raw = b;
    sw_req  = s;
    model_tick(r, b, s);
    if (r && !prev_r) begin
      #1;
      check("async_reset", {rst_req, busy, cause}, 4'b1111);
    end
    exp_q.push_back(model_out());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic hold(input int n, input logic r, input logic b, input logic s);
    for (int i = 0; i < n; i++) step(r, b, s);
  endtask

  // Monitor: after every rising edge, compare the DUT outputs with the next queued expectation.
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", {rst_req, busy, cause}, e);
      end
    end
  end

  // Stimulus: directed scenarios first, then random button, software and reset activity.
  initial begin
    int len;
    logic lvl;
    vectors = 0;
    errors  = 0;
    reset   = 1'b1;
    btn_raw = 1'b0;
    sw_req  = 1'b0;
    m_s1 = 1'b0; m_s2 = 1'b0;
    m_pulse_left = P; m_hold_age = -1; m_run = 0; m_cause = 2'b11;
    #1;
    check("reset_state", {rst_req, busy, cause}, 4'b1111);
    @(negedge clk);

    // Power-on sequence: stretched pulse, then hold-off, then idle.
    hold(3, 1'b1, 1'b0, 1'b0);
    hold(16, 1'b0, 1'b0, 1'b0);
    check("por_idle", {rst_req, busy, cause}, 4'b0011);

    // Clean press held for 20 cycles.
    hold(20, 1'b0, 1'b1, 1'b0);
    hold(16, 1'b0, 1'b0, 1'b0);
    check("press_cause", {rst_req, busy, cause}, 4'b0001);

    // Bouncing press that never reaches the debounce count.
    hold(5, 1'b0, 1'b1, 1'b0);
    hold(1, 1'b0, 1'b0, 1'b0);
    hold(5, 1'b0, 1'b1, 1'b0);
    hold(6, 1'b0, 1'b0, 1'b0);
    check("bounce_idle", {rst_req, busy, cause}, 4'b0001);

    // Software request, then a second request during hold-off that must be dropped.
    step(1'b0, 1'b0, 1'b1);
    hold(5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    hold(12, 1'b0, 1'b0, 1'b0);
    check("sw_cause", {rst_req, busy, cause}, 4'b0010);

    // Software request arriving mid-debounce while the button stays held.
    hold(7, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    hold(30, 1'b0, 1'b1, 1'b0);
    hold(12, 1'b0, 1'b0, 1'b0);

    // Reset during the second cycle of a button pulse.
    hold(11, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    hold(16, 1'b0, 1'b0, 1'b0);

    // Randomized activity.
    for (int seg = 0; seg < 150; seg++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 25);
      for (int i = 0; i < len; i++) begin
        step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, lvl,
             ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0);
      end
    end
    hold(20, 1'b0, 1'b0, 1'b0);

    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
